// File: rtl/arp_resolver_pkg.sv
// Shared constants, state encodings and address helpers for the ARP resolver.
package arp_resolver_pkg;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StQuery    = 3'd1;
    localparam logic [2:0] StWaitQ    = 3'd2;
    localparam logic [2:0] StSend     = 3'd3;
    localparam logic [2:0] StWaitRply = 3'd4;
    localparam logic [2:0] StResp     = 3'd5;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] IP_BCAST  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        error;
        logic [47:0] mac;
    } resp_t;

    // Limited broadcast or directed broadcast for the local subnet.
    function automatic logic is_bcast(input logic [31:0] ip, input logic [31:0] mask);
        return (ip == IP_BCAST) || ((ip | mask) == IP_BCAST);
    endfunction

    function automatic logic [31:0] next_hop(input logic [31:0] ip, input logic [31:0] self_ip,
                                             input logic [31:0] gw_ip, input logic [31:0] mask);
        return (((ip ^ self_ip) & mask) == 32'd0) ? ip : gw_ip;
    endfunction

endpackage

// File: rtl/arp_resolver_retry_timer.sv
// Loadable down counter with a zero flag; paces ARP request retries.
module arp_resolver_retry_timer #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/arp_resolver.sv
// Next-hop resolver: cache lookup, ARP request retries and reply capture.
// Define ARP_RESOLVER_STATS_EN to add saturating hit/miss/timeout counters.
module arp_resolver
    import arp_resolver_pkg::*;
#(
    parameter int unsigned RETRY_COUNT    = 4,
    parameter logic [31:0] RETRY_INTERVAL = 32'd125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_ip,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_error,
    output logic [47:0] resp_mac,
    output logic        cache_qreq_valid,
    input  logic        cache_qreq_ready,
    output logic [31:0] cache_qreq_ip,
    input  logic        cache_qresp_valid,
    output logic        cache_qresp_ready,
    input  logic        cache_qresp_error,
    input  logic [47:0] cache_qresp_mac,
    output logic        cache_wr_valid,
    input  logic        cache_wr_ready,
    output logic [31:0] cache_wr_ip,
    output logic [47:0] cache_wr_mac,
    input  logic        rx_reply_valid,
    input  logic [31:0] rx_reply_ip,
    input  logic [47:0] rx_reply_mac,
    output logic        tx_req_valid,
    input  logic        tx_req_ready,
    output logic [31:0] tx_req_ip,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
`ifdef ARP_RESOLVER_STATS_EN
    ,
    output logic [15:0] stat_hit,
    output logic [15:0] stat_miss,
    output logic [15:0] stat_timeout
`endif
);

    localparam logic [3:0] RetryMax = 4'(RETRY_COUNT);

    logic [2:0]  state_q, state_d;
    logic [31:0] lookup_ip_q, lookup_ip_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    resp_t       resp_q, resp_d;

    logic req_ready_q, cache_qreq_valid_q, cache_qresp_ready_q, tx_req_valid_q, resp_valid_q;

    logic        wr_valid_q;
    logic [31:0] wr_ip_q;
    logic [47:0] wr_mac_q;

    logic timer_load, timer_dec, timer_zero;

    logic req_fire, qreq_fire, qresp_fire, tx_fire, resp_fire, reply_match;

    assign req_fire    = req_valid && req_ready_q;
    assign qreq_fire   = cache_qreq_valid_q && cache_qreq_ready;
    assign qresp_fire  = cache_qresp_valid && cache_qresp_ready_q;
    assign tx_fire     = tx_req_valid_q && tx_req_ready;
    assign resp_fire   = resp_valid_q && resp_ready;
    assign reply_match = rx_reply_valid && (rx_reply_ip == lookup_ip_q);

    arp_resolver_retry_timer #(
        .Width (32)
    ) u_retry_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (RETRY_INTERVAL),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d     = state_q;
        lookup_ip_d = lookup_ip_q;
        retry_cnt_d = retry_cnt_q;
        resp_d      = resp_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    lookup_ip_d = next_hop(req_ip, local_ip, gateway_ip, subnet_mask);
                    if (is_bcast(req_ip, subnet_mask)) begin
                        resp_d  = '{error: 1'b0, mac: BCAST_MAC};
                        state_d = StResp;
                    end else begin
                        state_d = StQuery;
                    end
                end
            end
            StQuery: begin
                if (qreq_fire) begin
                    state_d = StWaitQ;
                end
            end
            StWaitQ: begin
                if (qresp_fire) begin
                    if (cache_qresp_error) begin
                        retry_cnt_d = 4'd0;
                        state_d     = StSend;
                    end else begin
                        resp_d  = '{error: 1'b0, mac: cache_qresp_mac};
                        state_d = StResp;
                    end
                end
            end
            StSend: begin
                if (tx_fire) begin
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    timer_load  = 1'b1;
                    state_d     = StWaitRply;
                end
            end
            StWaitRply: begin
                timer_dec = 1'b1;
                // A matching reply wins over a timeout landing in the same cycle.
                if (reply_match) begin
                    resp_d  = '{error: 1'b0, mac: rx_reply_mac};
                    state_d = StResp;
                end else if (timer_zero) begin
                    if (retry_cnt_q < RetryMax) begin
                        state_d = StSend;
                    end else begin
                        resp_d  = '{error: 1'b1, mac: 48'd0};
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are registered from the next state so no ready feeds a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StIdle;
            lookup_ip_q         <= 32'd0;
            retry_cnt_q         <= 4'd0;
            resp_q              <= '0;
            req_ready_q         <= 1'b0;
            cache_qreq_valid_q  <= 1'b0;
            cache_qresp_ready_q <= 1'b0;
            tx_req_valid_q      <= 1'b0;
            resp_valid_q        <= 1'b0;
        end else begin
            state_q             <= state_d;
            lookup_ip_q         <= lookup_ip_d;
            retry_cnt_q         <= retry_cnt_d;
            resp_q              <= resp_d;
            req_ready_q         <= (state_d == StIdle);
            cache_qreq_valid_q  <= (state_d == StQuery);
            cache_qresp_ready_q <= (state_d == StWaitQ);
            tx_req_valid_q      <= (state_d == StSend);
            resp_valid_q        <= (state_d == StResp);
        end
    end

    // One-deep cache write buffer; a new reply always replaces a pending one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_q <= 1'b0;
            wr_ip_q    <= 32'd0;
            wr_mac_q   <= 48'd0;
        end else if (rx_reply_valid) begin
            wr_valid_q <= 1'b1;
            wr_ip_q    <= rx_reply_ip;
            wr_mac_q   <= rx_reply_mac;
        end else if (wr_valid_q && cache_wr_ready) begin
            wr_valid_q <= 1'b0;
        end
    end

`ifdef ARP_RESOLVER_STATS_EN
    logic        ev_hit, ev_miss, ev_timeout;
    logic [15:0] stat_hit_q, stat_miss_q, stat_timeout_q;

    assign ev_hit     = (state_q == StWaitQ) && qresp_fire && !cache_qresp_error;
    assign ev_miss    = (state_q == StWaitQ) && qresp_fire && cache_qresp_error;
    assign ev_timeout = (state_q != StResp) && (state_d == StResp) && resp_d.error;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit_q     <= 16'd0;
            stat_miss_q    <= 16'd0;
            stat_timeout_q <= 16'd0;
        end else begin
            if (ev_hit && (stat_hit_q != 16'hFFFF)) begin
                stat_hit_q <= stat_hit_q + 16'd1;
            end
            if (ev_miss && (stat_miss_q != 16'hFFFF)) begin
                stat_miss_q <= stat_miss_q + 16'd1;
            end
            if (ev_timeout && (stat_timeout_q != 16'hFFFF)) begin
                stat_timeout_q <= stat_timeout_q + 16'd1;
            end
        end
    end

    assign stat_hit     = stat_hit_q;
    assign stat_miss    = stat_miss_q;
    assign stat_timeout = stat_timeout_q;
`endif

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_error        = resp_q.error;
    assign resp_mac          = resp_q.mac;
    assign cache_qreq_valid  = cache_qreq_valid_q;
    assign cache_qreq_ip     = lookup_ip_q;
    assign cache_qresp_ready = cache_qresp_ready_q;
    assign cache_wr_valid    = wr_valid_q;
    assign cache_wr_ip       = wr_ip_q;
    assign cache_wr_mac      = wr_mac_q;
    assign tx_req_valid      = tx_req_valid_q;
    assign tx_req_ip         = lookup_ip_q;

endmodule

// File: tb/tb_arp_resolver.sv
// Directed self-checking bench for arp_resolver (short retry settings).
module tb_arp_resolver;

    localparam int unsigned TbRetries  = 2;
    localparam logic [31:0] TbInterval = 32'd50;

    localparam logic [31:0] LocalIp = 32'h0A00_0002;
    localparam logic [31:0] GwIp    = 32'h0A00_0001;
    localparam logic [31:0] Mask    = 32'hFFFF_FF00;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [31:0] req_ip;
    logic        resp_valid, resp_ready, resp_error;
    logic [47:0] resp_mac;
    logic        cache_qreq_valid, cache_qreq_ready;
    logic [31:0] cache_qreq_ip;
    logic        cache_qresp_valid, cache_qresp_ready, cache_qresp_error;
    logic [47:0] cache_qresp_mac;
    logic        cache_wr_valid, cache_wr_ready;
    logic [31:0] cache_wr_ip;
    logic [47:0] cache_wr_mac;
    logic        rx_reply_valid;
    logic [31:0] rx_reply_ip;
    logic [47:0] rx_reply_mac;
    logic        tx_req_valid, tx_req_ready;
    logic [31:0] tx_req_ip;
    logic [31:0] local_ip, gateway_ip, subnet_mask;

    int n_cmp = 0;
    int n_mis = 0;

    int          cyc = 0;
    int          tx_cnt = 0, tx_last_cyc = 0, tx_prev_cyc = 0;
    logic [31:0] tx_last_ip = 32'd0;
    int          qreq_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_last_ip = 32'd0;
    logic [47:0] wr_last_mac = 48'd0;

    arp_resolver #(
        .RETRY_COUNT    (TbRetries),
        .RETRY_INTERVAL (TbInterval)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_ip            (req_ip),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_error        (resp_error),
        .resp_mac          (resp_mac),
        .cache_qreq_valid  (cache_qreq_valid),
        .cache_qreq_ready  (cache_qreq_ready),
        .cache_qreq_ip     (cache_qreq_ip),
        .cache_qresp_valid (cache_qresp_valid),
        .cache_qresp_ready (cache_qresp_ready),
        .cache_qresp_error (cache_qresp_error),
        .cache_qresp_mac   (cache_qresp_mac),
        .cache_wr_valid    (cache_wr_valid),
        .cache_wr_ready    (cache_wr_ready),
        .cache_wr_ip       (cache_wr_ip),
        .cache_wr_mac      (cache_wr_mac),
        .rx_reply_valid    (rx_reply_valid),
        .rx_reply_ip       (rx_reply_ip),
        .rx_reply_mac      (rx_reply_mac),
        .tx_req_valid      (tx_req_valid),
        .tx_req_ready      (tx_req_ready),
        .tx_req_ip         (tx_req_ip),
        .local_ip          (local_ip),
        .gateway_ip        (gateway_ip),
        .subnet_mask       (subnet_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_req_valid && tx_req_ready) begin
            tx_cnt      <= tx_cnt + 1;
            tx_prev_cyc <= tx_last_cyc;
            tx_last_cyc <= cyc;
            tx_last_ip  <= tx_req_ip;
        end
        if (cache_qreq_valid && cache_qreq_ready) begin
            qreq_cnt <= qreq_cnt + 1;
        end
        if (cache_wr_valid && cache_wr_ready) begin
            wr_cnt      <= wr_cnt + 1;
            wr_last_ip  <= cache_wr_ip;
            wr_last_mac <= cache_wr_mac;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic do_req(input logic [31:0] ip);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("req_ready_seen", 64'(seen), 64'd1);
        req_valid = 1'b1;
        req_ip    = ip;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic serve_query(input logic err, input logic [47:0] mac, output logic [31:0] ip);
        bit seen = 0;
        ip = 32'd0;
        for (int i = 0; i < 20; i++) begin
            if (cache_qreq_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("qreq_seen", 64'(seen), 64'd1);
        ip = cache_qreq_ip;
        @(posedge clk);
        @(negedge clk);
        cache_qresp_valid = 1'b1;
        cache_qresp_error = err;
        cache_qresp_mac   = mac;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cache_qresp_ready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("qresp_ready_seen", 64'(seen), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cache_qresp_valid = 1'b0;
    endtask

    task automatic wait_resp(input int bound, output logic err, output logic [47:0] mac,
                             output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < bound; i++) begin
            if (resp_valid) begin
                seen = 1;
                lat  = i;
                break;
            end
            @(negedge clk);
        end
        check_eq("resp_seen", 64'(seen), 64'd1);
        err = resp_error;
        mac = resp_mac;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic pulse_reply(input logic [31:0] ip, input logic [47:0] mac);
        rx_reply_valid = 1'b1;
        rx_reply_ip    = ip;
        rx_reply_mac   = mac;
        @(negedge clk);
        rx_reply_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] qip;
        logic        err;
        logic [47:0] mac, mac0;
        int          lat, tx0, q0, w0;
        bit          stable;

        rst = 1'b1;
        req_valid = 1'b0; req_ip = 32'd0; resp_ready = 1'b0;
        cache_qreq_ready = 1'b1; cache_qresp_valid = 1'b0; cache_qresp_error = 1'b0;
        cache_qresp_mac = 48'd0; cache_wr_ready = 1'b1;
        rx_reply_valid = 1'b0; rx_reply_ip = 32'd0; rx_reply_mac = 48'd0;
        tx_req_ready = 1'b1;
        local_ip = LocalIp; gateway_ip = GwIp; subnet_mask = Mask;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_valids", 64'({resp_valid, cache_qreq_valid, tx_req_valid, cache_wr_valid}),
                 64'd0);
        check_eq("rst_payload", 64'({resp_error, resp_mac}), 64'd0);
        rst = 1'b0;
        check_eq("rdy_before_edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        check_eq("rdy_after_edge", 64'(req_ready), 64'd1);

        // Cache hit, on-subnet
        tx0 = tx_cnt;
        do_req(32'h0A00_0005);
        check_eq("busy_req_ready", 64'(req_ready), 64'd0);
        serve_query(1'b0, 48'h02_00_00_00_00_05, qip);
        check_eq("hit_qip", 64'(qip), 64'h0A00_0005);
        wait_resp(20, err, mac, lat);
        check_eq("hit_err", 64'(err), 64'd0);
        check_eq("hit_mac", 64'(mac), 64'h02_00_00_00_00_05);
        ack_resp();
        check_eq("hit_resp_drop", 64'(resp_valid), 64'd0);
        check_eq("hit_req_ready", 64'(req_ready), 64'd1);
        check_eq("hit_no_tx", 64'(tx_cnt - tx0), 64'd0);

        // Off-subnet goes to the gateway
        do_req(32'h0808_0808);
        serve_query(1'b0, 48'h02_00_00_00_00_01, qip);
        check_eq("gw_qip", 64'(qip), 64'(GwIp));
        wait_resp(20, err, mac, lat);
        check_eq("gw_mac", 64'(mac), 64'h02_00_00_00_00_01);
        ack_resp();

        // Directed and limited broadcast: no cache access, response next cycle
        q0 = qreq_cnt;
        do_req(32'h0A00_00FF);
        wait_resp(3, err, mac, lat);
        check_eq("bcast_lat", 64'(lat), 64'd0);
        check_eq("bcast_mac", 64'({err, mac}), {15'd0, 1'b0, 48'hFFFF_FFFF_FFFF});
        ack_resp();
        do_req(32'hFFFF_FFFF);
        wait_resp(3, err, mac, lat);
        check_eq("lbcast_mac", 64'({err, mac}), {15'd0, 1'b0, 48'hFFFF_FFFF_FFFF});
        ack_resp();
        check_eq("bcast_no_query", 64'(qreq_cnt - q0), 64'd0);

        // Miss then reply; an unrelated reply must not resolve but is still cached
        tx0 = tx_cnt;
        w0  = wr_cnt;
        do_req(32'h0A00_0005);
        serve_query(1'b1, 48'd0, qip);
        repeat (10) @(negedge clk);
        pulse_reply(32'h0A00_0009, 48'h02_99_99_99_99_09);
        repeat (19) @(negedge clk);
        check_eq("miss_pending", 64'(resp_valid), 64'd0);
        check_eq("miss_tx_cnt", 64'(tx_cnt - tx0), 64'd1);
        check_eq("miss_tx_ip", 64'(tx_last_ip), 64'h0A00_0005);
        pulse_reply(32'h0A00_0005, 48'h02_AA_BB_CC_DD_05);
        wait_resp(5, err, mac, lat);
        check_eq("reply_resp", 64'({err, mac}), {15'd0, 1'b0, 48'h02_AA_BB_CC_DD_05});
        ack_resp();
        check_eq("reply_wr_cnt", 64'(wr_cnt - w0), 64'd2);
        check_eq("reply_wr", {wr_last_ip, 32'(wr_last_mac[31:0])}, {32'h0A00_0005, 32'hBBCC_DD05});
        check_eq("reply_one_tx", 64'(tx_cnt - tx0), 64'd1);

        // Write buffer under backpressure keeps only the newest reply
        w0 = wr_cnt;
        cache_wr_ready = 1'b0;
        pulse_reply(32'h0A00_0011, 48'h02_00_00_00_00_11);
        pulse_reply(32'h0A00_0012, 48'h02_00_00_00_00_12);
        check_eq("wrbuf_valid", 64'(cache_wr_valid), 64'd1);
        check_eq("wrbuf_newest", {cache_wr_ip, 32'(cache_wr_mac[31:0])},
                 {32'h0A00_0012, 32'h0000_0012});
        cache_wr_ready = 1'b1;
        @(negedge clk);
        check_eq("wrbuf_drop", 64'(cache_wr_valid), 64'd0);
        check_eq("wrbuf_one_wr", 64'(wr_cnt - w0), 64'd1);

        // Timeout after TbRetries requests
        tx0 = tx_cnt;
        do_req(32'h0A00_0007);
        serve_query(1'b1, 48'd0, qip);
        wait_resp(400, err, mac, lat);
        check_eq("to_resp", 64'({err, mac}), {15'd0, 1'b1, 48'd0});
        check_eq("to_tx_cnt", 64'(tx_cnt - tx0), 64'(TbRetries));
        // Zero is observed one cycle after reaching it, then the resend takes another.
        check_eq("to_tx_gap", 64'(tx_last_cyc - tx_prev_cyc), 64'(TbInterval) + 64'd2);
        ack_resp();

        // Response backpressure keeps payload stable
        do_req(32'h0A00_0006);
        serve_query(1'b0, 48'h02_00_00_00_00_06, qip);
        wait_resp(20, err, mac0, lat);
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_error || (resp_mac != mac0)) stable = 0;
        end
        check_eq("bp_stable", 64'(stable), 64'd1);
        check_eq("bp_mac", 64'(resp_mac), 64'h02_00_00_00_00_06);
        ack_resp();

        // Reset while waiting for a reply, with a cache write pending
        do_req(32'h0A00_0008);
        serve_query(1'b1, 48'd0, qip);
        cache_wr_ready = 1'b0;
        repeat (5) @(negedge clk);
        pulse_reply(32'h0A00_0063, 48'h02_00_00_00_00_63);
        check_eq("pre_rst_wr", 64'(cache_wr_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valids",
                 64'({resp_valid, cache_qreq_valid, tx_req_valid, cache_wr_valid, req_ready}),
                 64'd0);
        rst = 1'b0;
        cache_wr_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
